pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- aa, ba  in  5 each  DOF A/B source register addresses.
- a_used, b_used  in  1 each  DOF instruction reads A/B.
- da1, rw1  in  5, 1  EX-stage destination and write enable.
- da2, rw2  in  5, 1  WB-stage destination and write enable.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- halt_req  in  1  request to drain and halt.
- resume  in  1  leave HALTED.
- pc_hold  out  1  PC keeps its value.
- ifdof_hold  out  1  PCN1/IR keep their values.
- ifdof_flush  out  1  IR loads 0 (NOP).
- ex_bubble  out  1  DOF->EX register loads a bubble (RW=0, MW=0, BS=0, PS=0).
- halted  out  1  pipeline drained and stopped.
- stall_cycles  out  16  saturating stall-cycle count.
- flush_events  out  16  saturating flush count.

Function
REQ-003 The block SHALL compute the hazard combinationally: hz = (a_used & aa!=0 & ((rw1 & da1==aa) | (rw2 & da2==aa))) | (the same term for b_used/ba).
REQ-004 Register address 0 SHALL never cause a hazard.
REQ-005 Action priority SHALL be reset > branch_taken > FSM state (DRAIN/HALTED) > hz > idle.
REQ-006 All control outputs SHALL be combinational from the inputs and the current state, with zero-cycle latency.
REQ-007 Idle SHALL drive all control outputs to 0.
REQ-008 Branch SHALL drive ifdof_flush=1, ex_bubble=1, pc_hold=0, ifdof_hold=0.
REQ-009 Stall (hz=1 in RUN) SHALL drive pc_hold=1, ifdof_hold=1, ex_bubble=1, ifdof_flush=0.
REQ-010 The stall SHALL persist each cycle until hz falls; there is no forwarding.
REQ-011 The FSM SHALL have states RUN, DRAIN and HALTED; reset state is RUN.
REQ-012 RUN -> DRAIN SHALL occur when halt_req=1; the drain counter loads 2.
REQ-013 In DRAIN, outputs SHALL be pc_hold=1, ifdof_hold=1, ex_bubble=1; the counter decrements each cycle, and DRAIN -> HALTED occurs when it reaches 0.
REQ-014 In HALTED, outputs SHALL be halted=1 plus the DRAIN hold outputs; HALTED -> RUN occurs on resume=1, and halted falls in the next cycle.
REQ-015 branch_taken in DRAIN SHALL apply the branch outputs for that cycle, so PC loads the target, without altering the counter.
REQ-016 halt_req in DRAIN/HALTED and resume in RUN/DRAIN SHALL be ignored.
REQ-017 halt_req and hz asserted together in RUN SHALL take the stall outputs that cycle, and the state SHALL still move to DRAIN.

Reset
REQ-018 reset=0 SHALL asynchronously force state RUN, drain counter 0 and both counters 0.
REQ-019 During reset, outputs SHALL reflect idle RUN (halted=0); any drain in progress is abandoned.
REQ-020 Deassertion SHALL take effect at the first clock edge after release.

Configuration
REQ-021 With PIPE_HAZARD_PERF_EN defined, stall_cycles SHALL increment on every clock where the stall action applies (REQ-009) and flush_events on every branch_taken cycle, both saturating at 0xFFFF.
REQ-022 Without PIPE_HAZARD_PERF_EN, both counter ports SHALL be present and tied to 0, and no counter flops SHALL exist.

Structure
REQ-023 Package pipe_ctrl_pkg SHALL hold the state enum (RUN/DRAIN/HALTED), REG_ZERO=5'd0, DRAIN_CYCLES=2 and CNT_W=16.
REQ-024 One sub-module, hazard_cmp (one source port against both writer stages), SHALL be instantiated twice, for A and for B.

Verification
REQ-025 aa=3, a_used=1, rw1=1, da1=3 for two cycles, then rw2=1, da2=3 for one cycle -> pc_hold=ifdof_hold=ex_bubble=1 for 3 cycles and stall_cycles=3 (PERF on).
REQ-026 aa=0, a_used=1, rw1=1, da1=0 -> no stall; ba=5 with b_used=0 and da2=5 -> no stall.
REQ-027 branch_taken=1 together with hz=1 -> ifdof_flush=1, ex_bubble=1, pc_hold=0, and flush_events increments by 1.
REQ-028 halt_req pulse in RUN -> DRAIN for 2 cycles, then halted=1; resume -> halted=0 next cycle with outputs idle.
REQ-029 branch_taken in the first DRAIN cycle -> pc_hold=0 that cycle, and halted still asserts after 2 DRAIN cycles.
REQ-030 reset=0 asserted in the middle of DRAIN -> halted=0, state RUN and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters are enabled with PIPE_HAZARD_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned CNT_W        = 16;

    // Value loaded into the 2-bit drain counter on entry to DRAIN
    localparam logic [1:0]  DRAIN_LOAD   = 2'(DRAIN_CYCLES);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The stall/flush counter signals are present in every build; without
// PIPE_HAZARD_PERF_EN the controller ties them to zero.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0]       aa;
    logic [4:0]       ba;
    logic             a_used;
    logic             b_used;
    logic [4:0]       da1;
    logic             rw1;
    logic [4:0]       da2;
    logic             rw2;
    logic             branch_taken;
    logic             halt_req;
    logic             resume;
    logic             pc_hold;
    logic             ifdof_hold;
    logic             ifdof_flush;
    logic             ex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // Datapath / environment side
    modport master (
        output aa, ba, a_used, b_used, da1, rw1, da2, rw2,
               branch_taken, halt_req, resume,
        input  pc_hold, ifdof_hold, ifdof_flush, ex_bubble, halted,
               stall_cycles, flush_events
    );

    // Hazard controller side
    modport slave (
        input  aa, ba, a_used, b_used, da1, rw1, da2, rw2,
               branch_taken, halt_req, resume,
        output pc_hold, ifdof_hold, ifdof_flush, ex_bubble, halted,
               stall_cycles, flush_events
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Compares one DOF source register address against the EX and WB writers.
// Register 0 is hardwired and never produces a hazard.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  logic [4:0] da1_i,
    input  logic       rw1_i,
    input  logic [4:0] da2_i,
    input  logic       rw2_i,
    output logic       hit_o
);

    assign hit_o = used_i && (src_i != REG_ZERO) &&
                   ((rw1_i && (da1_i == src_i)) || (rw2_i && (da2_i == src_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / branch / halt controller.
// Control outputs are combinational from the inputs and the current state.
// Optional saturating stall/flush counters: define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    state_t     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic [1:0] drain_dec;
    logic       hit_a, hit_b, hz;
    logic       stall_act, flush_act;

    hazard_cmp u_cmp_a (
        .src_i  (bus.aa),
        .used_i (bus.a_used),
        .da1_i  (bus.da1),
        .rw1_i  (bus.rw1),
        .da2_i  (bus.da2),
        .rw2_i  (bus.rw2),
        .hit_o  (hit_a)
    );

    hazard_cmp u_cmp_b (
        .src_i  (bus.ba),
        .used_i (bus.b_used),
        .da1_i  (bus.da1),
        .rw1_i  (bus.rw1),
        .da2_i  (bus.da2),
        .rw2_i  (bus.rw2),
        .hit_o  (hit_b)
    );

    assign hz        = hit_a || hit_b;
    assign drain_dec = drain_q - 2'd1;

    // State and drain counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; a branch never disturbs the drain sequence
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                drain_d = drain_dec;
                if (drain_dec == '0) state_d = HALTED;
            end
            HALTED: begin
                if (bus.resume) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase
    end

    // Control outputs: reset > branch > DRAIN/HALTED > hazard > idle
    always_comb begin
        bus.pc_hold     = 1'b0;
        bus.ifdof_hold  = 1'b0;
        bus.ifdof_flush = 1'b0;
        bus.ex_bubble   = 1'b0;
        bus.halted      = 1'b0;
        stall_act       = 1'b0;
        flush_act       = 1'b0;
        if (reset) begin
            bus.halted = (state_q == HALTED);
            if (bus.branch_taken) begin
                bus.ifdof_flush = 1'b1;
                bus.ex_bubble   = 1'b1;
                flush_act       = 1'b1;
            end else if (state_q != RUN) begin
                bus.pc_hold    = 1'b1;
                bus.ifdof_hold = 1'b1;
                bus.ex_bubble  = 1'b1;
            end else if (hz) begin
                bus.pc_hold    = 1'b1;
                bus.ifdof_hold = 1'b1;
                bus.ex_bubble  = 1'b1;
                stall_act      = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating stall and flush event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_act && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_act && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_events = flush_cnt_q;
`else
    logic unused_act;
    assign unused_act       = stall_act ^ flush_act;
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl.
// Counter expectations follow PIPE_HAZARD_PERF_EN (zero when undefined).
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] aa;
        logic [4:0] ba;
        logic       a_used;
        logic       b_used;
        logic [4:0] da1;
        logic       rw1;
        logic [4:0] da2;
        logic       rw2;
        logic       br;
        logic [3:0] exp;   // {pc_hold, ifdof_hold, ifdof_flush, ex_bubble}
        string      name;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int unsigned stall_model = 0;
    int unsigned flush_model = 0;

    vec_t vecs [12];
    vec_t idle_v, hz_v, br_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef PIPE_HAZARD_PERF_EN
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cycles), stall_model);
        chk({tag, "_flush_cnt"}, 32'(bus.flush_events), flush_model);
`else
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cycles), 32'd0);
        chk({tag, "_flush_cnt"}, 32'(bus.flush_events), 32'd0);
`endif
    endtask

    function automatic logic [4:0] outs();
        return {bus.pc_hold, bus.ifdof_hold, bus.ifdof_flush, bus.ex_bubble, bus.halted};
    endfunction

    // One cycle: check counters from earlier cycles, drive, check outputs
    task automatic step(input vec_t v, input logic halt, input logic res,
                        input logic [4:0] exp5, input logic stall_inc, input string name);
        @(negedge clock);
        chk_counters(name);
        bus.aa           = v.aa;
        bus.ba           = v.ba;
        bus.a_used       = v.a_used;
        bus.b_used       = v.b_used;
        bus.da1          = v.da1;
        bus.rw1          = v.rw1;
        bus.da2          = v.da2;
        bus.rw2          = v.rw2;
        bus.branch_taken = v.br;
        bus.halt_req     = halt;
        bus.resume       = res;
        #1;
        chk(name, 32'(outs()), 32'(exp5));
        if (stall_inc) stall_model++;
        if (v.br) flush_model++;
    endtask

    function automatic vec_t mk(input logic [4:0] aa, input logic [4:0] ba,
                                input logic au, input logic bu,
                                input logic [4:0] da1, input logic rw1,
                                input logic [4:0] da2, input logic rw2,
                                input logic br, input logic [3:0] exp, input string name);
        vec_t v;
        v.aa = aa; v.ba = ba; v.a_used = au; v.b_used = bu;
        v.da1 = da1; v.rw1 = rw1; v.da2 = da2; v.rw2 = rw2;
        v.br = br; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        //           aa     ba     au bu da1    rw1 da2    rw2 br  exp
        vecs[0]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0,  5'd0,  0,  0, 4'b0000, "idle");
        vecs[1]  = mk(5'd3,  5'd0,  1, 0, 5'd3,  1,  5'd0,  0,  0, 4'b1101, "ex_hz_1");
        vecs[2]  = mk(5'd3,  5'd0,  1, 0, 5'd3,  1,  5'd0,  0,  0, 4'b1101, "ex_hz_2");
        vecs[3]  = mk(5'd3,  5'd0,  1, 0, 5'd0,  0,  5'd3,  1,  0, 4'b1101, "wb_hz");
        vecs[4]  = mk(5'd0,  5'd0,  1, 0, 5'd0,  1,  5'd0,  0,  0, 4'b0000, "r0_no_hz");
        vecs[5]  = mk(5'd0,  5'd5,  0, 0, 5'd0,  0,  5'd5,  1,  0, 4'b0000, "b_unused");
        vecs[6]  = mk(5'd0,  5'd5,  0, 1, 5'd0,  0,  5'd5,  1,  0, 4'b1101, "b_wb_hz");
        vecs[7]  = mk(5'd7,  5'd0,  1, 0, 5'd7,  1,  5'd0,  0,  1, 4'b0011, "br_over_hz");
        vecs[8]  = mk(5'd9,  5'd0,  1, 0, 5'd9,  0,  5'd0,  0,  0, 4'b0000, "rw_off");
        vecs[9]  = mk(5'd4,  5'd0,  1, 0, 5'd6,  1,  5'd8,  1,  0, 4'b0000, "addr_diff");
        vecs[10] = mk(5'd0,  5'd31, 0, 1, 5'd31, 1,  5'd0,  0,  0, 4'b1101, "b_ex_hz31");
        vecs[11] = mk(5'd0,  5'd0,  0, 0, 5'd0,  0,  5'd0,  0,  1, 4'b0011, "br_alone");
        idle_v = vecs[0];
        hz_v   = vecs[1];
        br_v   = vecs[11];

        bus.aa = '0; bus.ba = '0; bus.a_used = 0; bus.b_used = 0;
        bus.da1 = '0; bus.rw1 = 0; bus.da2 = '0; bus.rw2 = 0;
        bus.branch_taken = 0; bus.halt_req = 0; bus.resume = 0;

        // Reset state, with a branch pending to show reset wins
        #3;
        bus.branch_taken = 1;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk_counters("reset");
        bus.branch_taken = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Combinational vectors in RUN
        for (int i = 0; i < 12; i++)
            step(vecs[i], 1'b0, 1'b0, {vecs[i].exp, 1'b0},
                 (vecs[i].exp == 4'b1101) && !vecs[i].br, vecs[i].name);

        // Halt, drain, halted, ignored halt_req, resume
        step(idle_v, 1'b1, 1'b0, 5'b00000, 1'b0, "halt_run");
        step(idle_v, 1'b0, 1'b1, 5'b11010, 1'b0, "drain1");
        step(idle_v, 1'b0, 1'b0, 5'b11010, 1'b0, "drain2");
        step(idle_v, 1'b1, 1'b0, 5'b11011, 1'b0, "halted");
        step(idle_v, 1'b0, 1'b1, 5'b11011, 1'b0, "resume_cyc");
        step(idle_v, 1'b0, 1'b0, 5'b00000, 1'b0, "after_resume");

        // Branch in first DRAIN cycle does not extend the drain
        step(idle_v, 1'b1, 1'b0, 5'b00000, 1'b0, "halt_run2");
        step(br_v,   1'b0, 1'b0, 5'b00110, 1'b0, "drain1_br");
        step(idle_v, 1'b0, 1'b0, 5'b11010, 1'b0, "drain2_b");
        step(idle_v, 1'b0, 1'b0, 5'b11011, 1'b0, "halted_b");
        step(idle_v, 1'b0, 1'b1, 5'b11011, 1'b0, "resume_b");
        step(idle_v, 1'b0, 1'b0, 5'b00000, 1'b0, "idle_b");

        // halt_req with hazard: stall outputs, still enters DRAIN
        step(hz_v,   1'b1, 1'b0, 5'b11010, 1'b1, "halt_hz");
        step(idle_v, 1'b0, 1'b0, 5'b11010, 1'b0, "drain1_c");
        step(idle_v, 1'b0, 1'b0, 5'b11010, 1'b0, "drain2_c");
        step(idle_v, 1'b0, 1'b0, 5'b11011, 1'b0, "halted_c");
        step(idle_v, 1'b0, 1'b1, 5'b11011, 1'b0, "resume_c");

        // Asynchronous reset in the middle of DRAIN
        step(idle_v, 1'b1, 1'b0, 5'b00000, 1'b0, "halt_run3");
        step(idle_v, 1'b0, 1'b0, 5'b11010, 1'b0, "drain1_d");
        @(negedge clock);
        chk_counters("pre_rst");
        bus.branch_taken = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        stall_model = 0;
        flush_model = 0;
        chk("mid_rst_outs", 32'(outs()), 32'd0);
        chk_counters("mid_rst");
        @(negedge clock);
        bus.branch_taken = 1'b0;
        reset = 1'b1;
        step(idle_v, 1'b0, 1'b0, 5'b00000, 1'b0, "post_rst_run");
        step(hz_v,   1'b0, 1'b0, 5'b11010, 1'b1, "post_rst_hz");
        step(idle_v, 1'b0, 1'b0, 5'b00000, 1'b0, "post_rst_idle");
        @(negedge clock);
        chk_counters("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
